galapagos_stream_unpacker: RTL

- Sits directly downstream of the single-transfer AXI-Stream reader in the Galapagos→FINN bridge.
- Consumes the reader's output interface (valid/ready, data, tkeep, tlast).
- Strips the Galapagos header beat from each packet and buffers the payload beats in a small first-word-fall-through (FWFT) FIFO.
- Presents the payload as an AXI-Stream master to the FINN input, and counts completed packets.

---
 rtl/galapagos_stream_unpacker.sv | 123 ++++++++++++
 1 files changed

// File: rtl/galapagos_stream_unpacker.sv
// Galapagos->FINN bridge stage: strips the header beat of each packet and buffers payload in an FWFT FIFO.
// Header stripping is compiled in with `define GALAPAGOS_HDR_STRIP_EN; without it the block is a plain FWFT buffer.
module galapagos_stream_unpacker #(
    parameter int BUS_WIDTH = 16,
    parameter int FIFO_AW   = 3,
    parameter int CNT_W     = 16
) (
    input  logic                   i_clk,
    input  logic                   i_areset,
    input  logic                   i_input_valid,
    output logic                   o_input_ready,
    input  logic [BUS_WIDTH-1:0]   i_input_data,
    input  logic [BUS_WIDTH/8-1:0] i_input_tkeep,
    input  logic                   i_input_tlast,
    output logic                   o_tvalid,
    input  logic                   i_tready,
    output logic [BUS_WIDTH-1:0]   o_tdata,
    output logic [BUS_WIDTH/8-1:0] o_tkeep,
    output logic                   o_tlast,
    output logic [BUS_WIDTH-1:0]   o_header,
    output logic [CNT_W-1:0]       o_pkt_count,
    output logic [FIFO_AW:0]       o_fifo_level
);
    localparam int KEEP_W  = BUS_WIDTH / 8;
    localparam int ENTRY_W = BUS_WIDTH + KEEP_W + 1;
    localparam int DEPTH   = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_LEVEL = (FIFO_AW + 1)'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [FIFO_AW:0]   wr_ptr;
    logic [FIFO_AW:0]   rd_ptr;
    logic [FIFO_AW:0]   level;
    logic               full;
    logic               empty;
    logic               accept;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;

    // Pointers carry one extra bit so a full FIFO is distinguishable from an empty one.
    assign level  = wr_ptr - rd_ptr;
    assign full   = (level == FULL_LEVEL);
    assign empty  = (level == '0);
    assign accept = i_input_valid && o_input_ready;
    assign pop    = !empty && i_tready;

    assign head = empty ? '0 : mem[rd_ptr[FIFO_AW-1:0]];
    assign {o_tlast, o_tkeep, o_tdata} = head;
    assign o_tvalid     = !empty;
    assign o_fifo_level = level;

`ifdef GALAPAGOS_HDR_STRIP_EN
    localparam logic [0:0] S_HDR     = 1'b0;
    localparam logic [0:0] S_PAYLOAD = 1'b1;

    logic [0:0] state;

    // The header is never stored, so it can always be accepted.
    assign o_input_ready = (state == S_HDR) || !full;
    assign push          = accept && (state == S_PAYLOAD);

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state    <= S_HDR;
            o_header <= '0;
        end else if (accept) begin
            if (state == S_HDR) begin
                o_header <= i_input_data;
                if (!i_input_tlast) begin
                    state <= S_PAYLOAD;
                end
            end else if (i_input_tlast) begin
                state <= S_HDR;
            end
        end
    end
`else
    logic ready_en;

    // Holds ready low while reset is asserted and releases it on the first clock afterwards.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    assign o_input_ready = ready_en && !full;
    assign push          = accept;
    assign o_header      = '0;
`endif

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= {i_input_tlast, i_input_tkeep, i_input_data};
        end
    end

    // Every accepted tlast closes a packet, whether it was a header-only beat or the last payload beat.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            o_pkt_count <= '0;
        end else if (accept && i_input_tlast) begin
            o_pkt_count <= o_pkt_count + 1'b1;
        end
    end

endmodule
